// File: rtl/csi2_rx_pkt_parser.sv
// CSI-2 RX packet parser: decodes headers from the 2-lane byte stream, checks header ECC
// and payload CRC, and presents the payload as 16-bit words with byte enables.
module csi2_rx_pkt_parser #(
    parameter logic [5:0] SHORT_DT_MAX = 6'h0F,
    parameter bit         ECC_CHECK    = 1'b1
) (
    input  logic        byte_clk_i,
    input  logic        reset_n_i,
    input  logic [15:0] byte_data_i,
    input  logic        byte_valid_i,
    output logic        hdr_valid_o,
    output logic        sp_en_o,
    output logic        lp_en_o,
    output logic [1:0]  vc_o,
    output logic [5:0]  dt_o,
    output logic [15:0] wc_o,
    output logic        ecc_err_o,
    output logic [15:0] payload_o,
    output logic        payload_en_o,
    output logic [1:0]  payload_be_o,
    output logic        payload_last_o,
    output logic        pkt_done_o,
    output logic        crc_err_o,
    output logic        trunc_err_o
);

    // state   | meaning
    // IDLE    | waiting for a burst; first word carries DI and WC[7:0]
    // HDR1    | second header word: WC[15:8] and ECC
    // PAYLOAD | payload words, rem bytes still to come
    // CRC     | word holds the full received CRC
    // CRC_HI  | word low byte holds the received CRC high byte (odd WC)
    // DRAIN   | packet finished, discard until the burst ends
    typedef enum logic [2:0] {IDLE, HDR1, PAYLOAD, CRC, CRC_HI, DRAIN} state_t;

    state_t      state_q;
    logic [7:0]  di_q;
    logic [7:0]  wc_lo_q;
    logic [7:0]  crc_lo_q;
    logic [15:0] rem_q;
    logic [15:0] crc_q;

    logic [7:0]  lo_byte;
    logic [7:0]  hi_byte;
    logic [15:0] wc_full;
    logic [23:0] hdr_bits;
    logic [5:0]  ecc_calc;
    logic        ecc_bad;
    logic        is_short;
    logic [15:0] crc_one;
    logic [15:0] crc_two;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 16'h8408;
            else             r = r >> 1;
        end
        return r;
    endfunction

    always_comb begin
        lo_byte     = byte_data_i[7:0];
        hi_byte     = byte_data_i[15:8];
        wc_full     = {lo_byte, wc_lo_q};
        hdr_bits    = {lo_byte, wc_lo_q, di_q};
        ecc_calc[0] = ^(hdr_bits & 24'hF12CB7);
        ecc_calc[1] = ^(hdr_bits & 24'hF2555B);
        ecc_calc[2] = ^(hdr_bits & 24'h749A6D);
        ecc_calc[3] = ^(hdr_bits & 24'hB8E38E);
        ecc_calc[4] = ^(hdr_bits & 24'hDF03F0);
        ecc_calc[5] = ^(hdr_bits & 24'hEFFC00);
        ecc_bad     = ECC_CHECK && (ecc_calc != hi_byte[5:0]);
        is_short    = (di_q[5:0] <= SHORT_DT_MAX);
        crc_one     = crc_byte(crc_q, lo_byte);
        crc_two     = crc_byte(crc_one, hi_byte);
    end

    always_ff @(posedge byte_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q        <= IDLE;
            di_q           <= '0;
            wc_lo_q        <= '0;
            crc_lo_q       <= '0;
            rem_q          <= '0;
            crc_q          <= 16'hFFFF;
            hdr_valid_o    <= 1'b0;
            sp_en_o        <= 1'b0;
            lp_en_o        <= 1'b0;
            vc_o           <= '0;
            dt_o           <= '0;
            wc_o           <= '0;
            ecc_err_o      <= 1'b0;
            payload_o      <= '0;
            payload_en_o   <= 1'b0;
            payload_be_o   <= '0;
            payload_last_o <= 1'b0;
            pkt_done_o     <= 1'b0;
            crc_err_o      <= 1'b0;
            trunc_err_o    <= 1'b0;
        end else begin
            hdr_valid_o    <= 1'b0;
            sp_en_o        <= 1'b0;
            lp_en_o        <= 1'b0;
            ecc_err_o      <= 1'b0;
            payload_en_o   <= 1'b0;
            payload_last_o <= 1'b0;
            pkt_done_o     <= 1'b0;
            crc_err_o      <= 1'b0;
            trunc_err_o    <= 1'b0;
            if (!byte_valid_i && (state_q inside {HDR1, PAYLOAD, CRC, CRC_HI})) begin
                trunc_err_o <= 1'b1;
                crc_q       <= 16'hFFFF;
                state_q     <= IDLE;
            end else begin
                case (state_q)
                    IDLE: if (byte_valid_i) begin
                        di_q    <= lo_byte;
                        wc_lo_q <= hi_byte;
                        state_q <= HDR1;
                    end
                    HDR1: begin
                        hdr_valid_o <= 1'b1;
                        vc_o        <= di_q[7:6];
                        dt_o        <= di_q[5:0];
                        wc_o        <= wc_full;
                        ecc_err_o   <= ecc_bad;
                        crc_q       <= 16'hFFFF;
                        rem_q       <= wc_full;
                        if (is_short) begin
                            sp_en_o    <= 1'b1;
                            pkt_done_o <= 1'b1;
                            state_q    <= DRAIN;
                        end else begin
                            lp_en_o <= 1'b1;
                            // a corrupted header cannot be trusted for payload framing
                            if (ecc_bad) begin
                                pkt_done_o <= 1'b1;
                                state_q    <= DRAIN;
                            end else if (wc_full == 16'h0000) begin
                                state_q <= CRC;
                            end else begin
                                state_q <= PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        payload_en_o <= 1'b1;
                        if (rem_q == 16'd1) begin
                            payload_o      <= {8'h00, lo_byte};
                            payload_be_o   <= 2'b01;
                            payload_last_o <= 1'b1;
                            crc_q          <= crc_one;
                            crc_lo_q       <= hi_byte;
                            state_q        <= CRC_HI;
                        end else begin
                            payload_o    <= byte_data_i;
                            payload_be_o <= 2'b11;
                            crc_q        <= crc_two;
                            if (rem_q == 16'd2) begin
                                payload_last_o <= 1'b1;
                                state_q        <= CRC;
                            end else begin
                                rem_q <= rem_q - 16'd2;
                            end
                        end
                    end
                    CRC: begin
                        pkt_done_o <= 1'b1;
                        crc_err_o  <= (byte_data_i != crc_q);
                        state_q    <= DRAIN;
                    end
                    CRC_HI: begin
                        pkt_done_o <= 1'b1;
                        crc_err_o  <= ({lo_byte, crc_lo_q} != crc_q);
                        state_q    <= DRAIN;
                    end
                    DRAIN: if (!byte_valid_i) state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_csi2_rx_pkt_parser.sv
// Bench for csi2_rx_pkt_parser: directed and random bursts compared against a
// packet-level model (table-driven CRC, column-code ECC).
module tb_csi2_rx_pkt_parser;

    logic        byte_clk_i = 1'b0;
    logic        reset_n_i;
    logic [15:0] byte_data_i;
    logic        byte_valid_i;
    logic        hdr_valid_o, sp_en_o, lp_en_o, ecc_err_o;
    logic [1:0]  vc_o;
    logic [5:0]  dt_o;
    logic [15:0] wc_o, payload_o;
    logic        payload_en_o, payload_last_o, pkt_done_o, crc_err_o, trunc_err_o;
    logic [1:0]  payload_be_o;

    csi2_rx_pkt_parser dut (
        .byte_clk_i    (byte_clk_i),
        .reset_n_i     (reset_n_i),
        .byte_data_i   (byte_data_i),
        .byte_valid_i  (byte_valid_i),
        .hdr_valid_o   (hdr_valid_o),
        .sp_en_o       (sp_en_o),
        .lp_en_o       (lp_en_o),
        .vc_o          (vc_o),
        .dt_o          (dt_o),
        .wc_o          (wc_o),
        .ecc_err_o     (ecc_err_o),
        .payload_o     (payload_o),
        .payload_en_o  (payload_en_o),
        .payload_be_o  (payload_be_o),
        .payload_last_o(payload_last_o),
        .pkt_done_o    (pkt_done_o),
        .crc_err_o     (crc_err_o),
        .trunc_err_o   (trunc_err_o)
    );

    always #5 byte_clk_i = ~byte_clk_i;

    // syndrome column of each header bit D0..D23
    localparam logic [5:0] ECC_COL [24] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

    localparam logic [7:0] SPEC_PL [24] = '{
        8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
        8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
        8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int trunc_cnt = 0;
    int stray_cnt = 0;
    logic [26:0] hdr_q[$];
    int          hdr_cyc_q[$];
    logic [18:0] pay_q[$];
    logic        done_q[$];
    int          done_cyc_q[$];
    logic [7:0]  pl_q[$];
    logic [15:0] crc_tab [256];
    logic [50:0] out_vec;

    assign out_vec = {hdr_valid_o, sp_en_o, lp_en_o, vc_o, dt_o, wc_o, ecc_err_o, payload_o,
                      payload_en_o, payload_be_o, payload_last_o, pkt_done_o, crc_err_o, trunc_err_o};

    always @(negedge byte_clk_i) begin
        cyc++;
        if (hdr_valid_o) begin
            hdr_q.push_back({vc_o, dt_o, wc_o, sp_en_o, lp_en_o, ecc_err_o});
            hdr_cyc_q.push_back(cyc);
        end
        if (payload_en_o) pay_q.push_back({payload_o, payload_be_o, payload_last_o});
        if (pkt_done_o) begin
            done_q.push_back(crc_err_o);
            done_cyc_q.push_back(cyc);
        end
        if (trunc_err_o) trunc_cnt++;
        if (!hdr_valid_o && (sp_en_o || lp_en_o || ecc_err_o)) stray_cnt++;
        if (!payload_en_o && payload_last_o) stray_cnt++;
        if (!pkt_done_o && crc_err_o) stray_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] model_ecc(input logic [23:0] d);
        logic [5:0] e = '0;
        for (int i = 0; i < 24; i++) if (d[i]) e ^= ECC_COL[i];
        return e;
    endfunction

    function automatic logic [15:0] model_crc(input int len);
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < len; i++) c = (c >> 8) ^ crc_tab[c[7:0] ^ pl_q[i]];
        return c;
    endfunction

    // cut: -1 whole burst, -2 random truncation point, >=0 number of words sent
    task automatic run_packet(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] ecc_tx,
                              input bit use_crc, input logic [15:0] crc_tx, input int cut,
                              input int trailer, input string name);
        logic [7:0]  b[$];
        logic [15:0] w[$];
        logic [15:0] crc_model, crc_sent;
        bit          is_short, ecc_ok, long_ok;
        int          needed, n, pw, exp_pay;
        is_short  = (di[5:0] <= 6'h0F);
        ecc_ok    = (model_ecc({wc, di}) == ecc_tx[5:0]);
        long_ok   = !is_short && ecc_ok;
        crc_model = is_short ? 16'hFFFF : model_crc(int'(wc));
        crc_sent  = use_crc ? crc_tx : crc_model;
        b.push_back(di);
        b.push_back(wc[7:0]);
        b.push_back(wc[15:8]);
        b.push_back(ecc_tx);
        if (!is_short) begin
            for (int i = 0; i < int'(wc); i++) b.push_back(pl_q[i]);
            b.push_back(crc_sent[7:0]);
            b.push_back(crc_sent[15:8]);
        end
        if (b.size() % 2 == 1) b.push_back(8'($urandom));
        for (int i = 0; i < b.size(); i += 2) w.push_back({b[i+1], b[i]});
        needed = long_ok ? (int'(wc) + 7) / 2 : 2;
        if (cut == -2)     n = $urandom_range(needed - 1, 1);
        else if (cut < 0)  n = w.size();
        else               n = cut;
        pw      = long_ok ? (int'(wc) + 1) / 2 : 0;
        exp_pay = (n - 2 < 0) ? 0 : ((n - 2 > pw) ? pw : n - 2);

        hdr_q.delete(); hdr_cyc_q.delete(); pay_q.delete(); done_q.delete(); done_cyc_q.delete();
        trunc_cnt = 0;
        stray_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge byte_clk_i); #1;
            byte_valid_i = 1'b1;
            byte_data_i  = w[i];
        end
        if (n == w.size()) begin
            for (int i = 0; i < trailer; i++) begin
                @(posedge byte_clk_i); #1;
                byte_data_i = 16'($urandom);
            end
        end
        @(posedge byte_clk_i); #1;
        byte_valid_i = 1'b0;
        byte_data_i  = 16'($urandom);
        repeat (4) @(posedge byte_clk_i);
        #1;

        check({name, " hdr count"}, hdr_q.size(), n >= 2);
        if (hdr_q.size() > 0 && n >= 2)
            check({name, " hdr fields"}, hdr_q[0], {di[7:6], di[5:0], wc, is_short, !is_short, !ecc_ok});
        check({name, " payload count"}, pay_q.size(), exp_pay);
        for (int k = 0; k < pay_q.size() && k < exp_pay; k++) begin
            logic [7:0] hb;
            logic [1:0] be;
            hb = (2*k + 1 < int'(wc)) ? pl_q[2*k+1] : 8'h00;
            be = (2*k + 1 < int'(wc)) ? 2'b11 : 2'b01;
            check($sformatf("%s payload word %0d", name, k), pay_q[k], {hb, pl_q[2*k], be, k == pw - 1});
        end
        check({name, " done count"}, done_q.size(), n >= needed);
        if (done_q.size() > 0 && n >= needed) begin
            check({name, " crc_err"}, done_q[0], long_ok && (crc_sent != crc_model));
            if (!long_ok && hdr_cyc_q.size() > 0)
                check({name, " done with hdr"}, done_cyc_q[0], hdr_cyc_q[0]);
        end
        check({name, " trunc count"}, trunc_cnt, n < needed);
        check({name, " stray flags"}, stray_cnt, 0);
    endtask

    initial begin
        logic [7:0]  di;
        logic [15:0] wc;
        logic [7:0]  ecc;

        for (int v = 0; v < 256; v++) begin
            logic [15:0] c;
            c = 16'(v);
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
            crc_tab[v] = c;
        end

        reset_n_i    = 1'b0;
        byte_valid_i = 1'b0;
        byte_data_i  = 16'h0000;
        repeat (3) @(posedge byte_clk_i);
        #1;
        check("reset outputs", out_vec, '0);
        reset_n_i = 1'b1;
        repeat (2) @(posedge byte_clk_i);

        run_packet(8'h00, 16'h0000, 8'h00, 1'b0, 16'h0, -1, 0, "short fs");

        pl_q.delete();
        for (int i = 0; i < 24; i++) pl_q.push_back(SPEC_PL[i]);
        di = {2'd1, 6'h2B};
        wc = 16'd24;
        ecc = {2'b00, model_ecc({wc, di})};
        run_packet(di, wc, ecc, 1'b1, 16'h00F0, -1, 2, "long even");
        run_packet(di, wc, ecc, 1'b1, 16'h00F1, -1, 0, "long bad crc");
        run_packet(di, wc, ecc ^ 8'h01, 1'b0, 16'h0, -1, 3, "ecc err");

        pl_q.delete();
        pl_q.push_back(8'h11); pl_q.push_back(8'h22); pl_q.push_back(8'h33);
        di = 8'h2A;
        wc = 16'd3;
        run_packet(di, wc, {2'b11, model_ecc({wc, di})}, 1'b0, 16'h0, -1, 1, "odd wc3");

        di = 8'h12;
        wc = 16'd0;
        run_packet(di, wc, {2'b00, model_ecc({wc, di})}, 1'b0, 16'h0, -1, 0, "long wc0");

        pl_q.delete();
        for (int i = 0; i < 100; i++) pl_q.push_back(8'($urandom));
        di = 8'h2A;
        wc = 16'd100;
        run_packet(di, wc, {2'b00, model_ecc({wc, di})}, 1'b0, 16'h0, 12, 0, "trunc wc100");
        run_packet(8'h00, 16'h0000, 8'h00, 1'b0, 16'h0, -1, 0, "fs after trunc");

        // reset asserted between clock edges while payload is flowing
        wc = 16'd20;
        di = 8'h6A;
        @(posedge byte_clk_i); #1;
        byte_valid_i = 1'b1;
        byte_data_i  = {wc[7:0], di};
        @(posedge byte_clk_i); #1;
        byte_data_i  = {2'b00, model_ecc({wc, di}), wc[15:8]};
        for (int i = 0; i < 3; i++) begin
            @(posedge byte_clk_i); #1;
            byte_data_i = {pl_q[2*i+1], pl_q[2*i]};
        end
        @(posedge byte_clk_i); #3;
        check("payload before reset", payload_en_o, 1'b1);
        reset_n_i = 1'b0;
        #1;
        check("outputs in reset", out_vec, '0);
        @(posedge byte_clk_i); #1;
        byte_valid_i = 1'b0;
        @(negedge byte_clk_i);
        reset_n_i = 1'b1;
        repeat (2) @(posedge byte_clk_i);
        run_packet(8'h00, 16'h0000, 8'h00, 1'b0, 16'h0, -1, 0, "fs after reset");

        for (int t = 0; t < 40; t++) begin
            logic [7:0]  rdi;
            logic [15:0] rwc;
            logic [7:0]  recc;
            rdi = 8'($urandom);
            rwc = ($urandom_range(3, 0) == 0) ? 16'h0000 : 16'($urandom_range(40, 1));
            pl_q.delete();
            for (int i = 0; i < int'(rwc); i++) pl_q.push_back(8'($urandom));
            recc = {2'($urandom), model_ecc({rwc, rdi})};
            if ($urandom_range(5, 0) == 0) recc = recc ^ (8'h01 << $urandom_range(5, 0));
            run_packet(rdi, rwc, recc, $urandom_range(3, 0) == 0, 16'($urandom),
                       ($urandom_range(4, 0) == 0) ? -2 : -1, $urandom_range(3, 0),
                       $sformatf("rnd%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/csi2_rx_pkt_parser.md
Name: csi2_rx_pkt_parser

Overview:
- Receive-side counterpart of the CSI-2 D-PHY transmit path.
- Takes the 2-lane, byte-aligned HS stream from the RX D-PHY (SoT already stripped) and parses CSI-2 packet headers.
- Reports short and long packets, strips and checks the payload CRC, and presents the payload as 16-bit words.
- Sits between the RX D-PHY byte interface and the pixel unpacker; the output header fields mirror the TX-side dt/vc/wc/sp_en/lp_en controls.

Parameters:
- SHORT_DT_MAX, 6'h0F: data types less than or equal to this value are short packets; all others are long.
- ECC_CHECK, 1: 1 enables the header ECC check; 0 forces ecc_err_o to 0.

Ports:
- byte_clk_i, in, 1: RX byte clock; all logic is on its rising edge.
- reset_n_i, in, 1: asynchronous active-low reset.
- byte_data_i, in, 16: {lane1 byte, lane0 byte}; the lane0 byte is earlier in the stream.
- byte_valid_i, in, 1: high for the whole HS burst; low means LP/EoT.
- hdr_valid_o, out, 1: one-cycle pulse when the header fields are valid.
- sp_en_o, out, 1: one-cycle pulse with hdr_valid_o for a short packet.
- lp_en_o, out, 1: one-cycle pulse with hdr_valid_o for a long packet.
- vc_o, out, 2: virtual channel, DI[7:6].
- dt_o, out, 6: data type, DI[5:0].
- wc_o, out, 16: word count (long packet) or short-packet data field.
- ecc_err_o, out, 1: with hdr_valid_o; received ECC[5:0] differs from the computed ECC.
- payload_o, out, 16: payload word.
- payload_en_o, out, 1: payload_o valid.
- payload_be_o, out, 2: byte enables; 2'b11 normally, 2'b01 for the last word of an odd WC.
- payload_last_o, out, 1: with payload_en_o on the final payload word.
- pkt_done_o, out, 1: one-cycle pulse at packet end.
- crc_err_o, out, 1: with pkt_done_o for long packets; CRC mismatch.
- trunc_err_o, out, 1: one-cycle pulse when byte_valid_i drops mid-packet.

Behaviour:
- Reset: all outputs 0; state IDLE; CRC register 16'hFFFF; counters 0.
- All outputs are registered. Pulses last exactly one cycle.
- States: IDLE, HDR1, PAYLOAD, CRC, CRC_HI, DRAIN.
- IDLE, byte_valid_i=1: latch DI = low byte and WC[7:0] = high byte; go to HDR1.
- HDR1, byte_valid_i=1: latch WC[15:8] = low byte and ECC = high byte. On the next cycle assert hdr_valid_o with sp_en_o or lp_en_o.
- ECC: 6-bit Hamming over {WC[15:8], WC[7:0], DI} per the MIPI CSI-2 v1.1 parity table. ECC[7:6] is ignored. Errors are detected only, never corrected.
- Short packet: pkt_done_o in the same cycle as hdr_valid_o; go to DRAIN.
- Long packet with ecc_err_o=1: payload is suppressed, no crc_err_o; pkt_done_o with hdr_valid_o; go to DRAIN.
- Long packet with WC=0: go to CRC.
- Long packet with WC>0: go to PAYLOAD with rem=WC and CRC register seeded 16'hFFFF.
- PAYLOAD, per valid word: drive payload_en_o one cycle later.
  - rem>=3: be=11, rem-=2.
  - rem==2: be=11, payload_last_o=1; go to CRC.
  - rem==1: be=01, payload_last_o=1, payload_o[15:8]=0. The high byte is the received CRC low byte; go to CRC_HI.
- CRC algorithm: CRC-16, poly x^16+x^12+x^5+1, LSB-first (reflected 16'h8408), seed FFFF, no final XOR. Only payload bytes are processed, two bytes per cycle, lane0 byte first. This needs a combinational 2-byte update.
- CRC state: received CRC = {high byte, low byte}. CRC_HI state: received CRC high = low byte; the high byte is ignored.
- End of CRC/CRC_HI: on the next cycle pulse pkt_done_o, with crc_err_o = (received != computed). Go to DRAIN.
- DRAIN: ignore data until byte_valid_i=0, then go to IDLE. Only one packet is parsed per HS burst.
- byte_valid_i=0 in HDR1, PAYLOAD, CRC or CRC_HI: pulse trunc_err_o, no pkt_done_o, go to IDLE, reseed the CRC. A payload word already accepted is still output.
- byte_valid_i=0 in IDLE or DRAIN: no action.
- WC=16'hFFFF is legal. rem is 16 bits and never wraps below 0.
- Reset asserted mid-packet: outputs clear immediately; parsing restarts at the next burst.

Test Plan:
- Short frame start: burst words 16'h0000, 16'h0000, then byte_valid_i low. Expect hdr_valid_o, sp_en_o and pkt_done_o on the cycle after word 2, with dt=0, vc=0, wc=0, ecc_err_o=0.
- Long even packet: DT=6'h2B, VC=1, WC=24, ECC from the bench model. Payload bytes FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01, then CRC bytes F0 00.
  - Expect 12 payload words, the first 16'h00FF, be=11; payload_last_o on word 12.
  - Expect pkt_done_o with crc_err_o=0.
  - Repeat with CRC 16'h00F1: expect crc_err_o=1.
- Odd WC=3: bytes 11 22 33 plus the correct CRC. Expect payload words 16'h2211 (be=11) then 16'h0033 (be=01, last); the CRC is taken from split words; crc_err_o=0.
- ECC error: valid long header with ECC bit 0 flipped. Expect hdr_valid_o with ecc_err_o=1, lp_en_o=1, no payload_en_o, pkt_done_o pulse, then DRAIN until byte_valid_i low.
- Truncation: WC=100 long packet, byte_valid_i low after 10 payload words. Expect trunc_err_o pulse, no pkt_done_o; the next burst (short FS) parses correctly.
- Reset mid-payload: assert reset_n_i=0 asynchronously during PAYLOAD. All outputs are 0 the same cycle; after release the next burst parses normally.
